// File: rtl/ami_credit_scheduler_pkg.sv
// ami_credit_scheduler_pkg: shared sizes, reset defaults and FSM state type for the credit scheduler
package ami_credit_scheduler_pkg;
   localparam int AMI_NUM_APPS            = 4;
   localparam int AMI_APP_BITS            = 3;
   localparam int AMI_SCHED_CNT_BITS      = 4;
   localparam int AMI_SCHED_WGT_BITS      = 4;
   localparam int AMI_SCHED_DEFAULT_LIMIT = 8;
   localparam int AMI_SCHED_DEFAULT_WGT   = 1;
   typedef enum logic {IDLE, HOLD} AMI_SCHED_STATE_T;
   function automatic int ami_idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/ami_credit_scheduler_rr.sv
// rr_next_picker: first set bit of eligible searching upward from start with wraparound
module rr_next_picker
   import ami_credit_scheduler_pkg::*;
#(
   parameter int N  = AMI_NUM_APPS,
   parameter int IB = ami_idx_bits(N)
) (
   input  logic [N-1:0]  eligible,
   input  logic [IB-1:0] start,
   output logic [N-1:0]  onehot,
   output logic [IB-1:0] idx,
   output logic          any
);
   // scan N positions from start, keep the first hit
   always_comb begin
      logic [IB-1:0] c;
      c      = '0;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int k = 0; k < N; k++) begin
         c = IB'((int'(start) + k) % N);
         if (!any && eligible[c]) begin
            any       = 1'b1;
            onehot[c] = 1'b1;
            idx       = c;
         end
      end
   end
endmodule

// File: rtl/ami_credit_scheduler.sv
// ami_credit_scheduler: weighted round-robin grant with per-app outstanding-read credit limits
module ami_credit_scheduler
   import ami_credit_scheduler_pkg::*;
#(
   parameter int N        = AMI_NUM_APPS,
   parameter int CNT_BITS = AMI_SCHED_CNT_BITS,
   parameter int WGT_BITS = AMI_SCHED_WGT_BITS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N-1:0]            req,
   input  logic [N-1:0]            is_read,
   output logic [N-1:0]            grant,
   input  logic                    resp_done,
   input  logic [AMI_APP_BITS-1:0] resp_app,
   input  logic                    cfg_wr,
   input  logic [AMI_APP_BITS-1:0] cfg_app,
   input  logic [CNT_BITS-1:0]     cfg_limit,
   input  logic [WGT_BITS-1:0]     cfg_weight,
   output logic                    all_idle,
   output logic                    err_underflow
);
   localparam int IB = ami_idx_bits(N);

   AMI_SCHED_STATE_T    state, state_nxt;
   logic [IB-1:0]       owner, last_owner, base, start, pick_idx, gidx;
   logic [WGT_BITS-1:0] burst_cnt, owner_wgt;
   logic [CNT_BITS-1:0] cnt [N];
   logic [CNT_BITS-1:0] limit [N];
   logic [WGT_BITS-1:0] weight [N];
   logic [N-1:0]        eligible, pick_oh, rd_inc, rd_dec, is_zero;
   logic                pick_any, owner_ok;

   // eligibility, response decode and zero detection per app
   always_comb begin
      eligible = '0;
      rd_dec   = '0;
      is_zero  = '0;
      for (int i = 0; i < N; i++) begin
         eligible[i] = req[i] && (!is_read[i] || cnt[i] < limit[i]);
         rd_dec[i]   = resp_done && resp_app == AMI_APP_BITS'(i);
         is_zero[i]  = cnt[i] == '0;
      end
   end

   assign rd_inc    = grant & is_read;
   assign all_idle  = &is_zero;
   assign owner_wgt = (weight[owner] == '0) ? WGT_BITS'(1) : weight[owner];
   assign owner_ok  = state == HOLD && eligible[owner] && burst_cnt < owner_wgt;
   assign base      = (state == HOLD) ? owner : last_owner;
   assign start     = (base == IB'(N - 1)) ? '0 : base + IB'(1);

   rr_next_picker #(.N(N), .IB(IB)) u_pick (
      .eligible (eligible),
      .start    (start),
      .onehot   (pick_oh),
      .idx      (pick_idx),
      .any      (pick_any)
   );

   // next state and zero-latency grant: keep the owner while its burst lasts, else rotate
   always_comb begin
      state_nxt = (owner_ok || pick_any) ? HOLD : IDLE;
      gidx      = owner_ok ? owner : pick_idx;
      grant     = rst ? '0 : owner_ok ? N'(1) << owner : pick_oh;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // owner, rotation pointer and burst length tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         owner      <= '0;
         last_owner <= IB'(N - 1);
         burst_cnt  <= '0;
      end else if (|grant) begin
         owner      <= gidx;
         last_owner <= gidx;
         burst_cnt  <= owner_ok ? burst_cnt + WGT_BITS'(1) : WGT_BITS'(1);
      end else begin
         burst_cnt  <= '0;
      end
   end

   // outstanding-read credits, per-app configuration and sticky underflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         err_underflow <= 1'b0;
         for (int i = 0; i < N; i++) begin
            cnt[i]    <= '0;
            limit[i]  <= CNT_BITS'(AMI_SCHED_DEFAULT_LIMIT);
            weight[i] <= WGT_BITS'(AMI_SCHED_DEFAULT_WGT);
         end
      end else begin
         if (|(rd_dec & is_zero)) err_underflow <= 1'b1;
         for (int i = 0; i < N; i++) begin
            if (rd_inc[i] && !rd_dec[i]) cnt[i] <= cnt[i] + CNT_BITS'(1);
            else if (rd_dec[i] && !rd_inc[i] && !is_zero[i]) cnt[i] <= cnt[i] - CNT_BITS'(1);
            if (cfg_wr && cfg_app == AMI_APP_BITS'(i)) begin
               limit[i]  <= cfg_limit;
               weight[i] <= cfg_weight;
            end
         end
      end
   end
endmodule

// File: tb/tb_ami_credit_scheduler.sv
// tb_ami_credit_scheduler: directed vectors with a queued scoreboard checked at the falling edge
module tb_ami_credit_scheduler;
   import ami_credit_scheduler_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0, is_read = '0, grant;
   logic       resp_done = 1'b0;
   logic [2:0] resp_app = '0;
   logic       cfg_wr = 1'b0;
   logic [2:0] cfg_app = '0;
   logic [3:0] cfg_limit = '0, cfg_weight = '0;
   logic       all_idle, err_underflow;

   typedef struct {
      string      nm;
      logic [3:0] g;
      logic       ci;
      logic       idle;
      logic       ce;
      logic       err;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   ami_credit_scheduler #(.N(4), .CNT_BITS(4), .WGT_BITS(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .is_read       (is_read),
      .grant         (grant),
      .resp_done     (resp_done),
      .resp_app      (resp_app),
      .cfg_wr        (cfg_wr),
      .cfg_app       (cfg_app),
      .cfg_limit     (cfg_limit),
      .cfg_weight    (cfg_weight),
      .all_idle      (all_idle),
      .err_underflow (err_underflow)
   );

   task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] rd,
                      input logic rdn, input logic [2:0] ra, input logic [3:0] eg,
                      input logic ci, input logic ei, input logic ce, input logic ee,
                      input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; req = rq; is_read = rd; resp_done = rdn; resp_app = ra; cfg_wr = 1'b0;
      e.nm = nm; e.g = eg; e.ci = ci; e.idle = ei; e.ce = ce; e.err = ee;
      q.push_back(e);
   endtask

   task automatic cfg(input logic [2:0] a, input logic [3:0] l, input logic [3:0] w, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst = 1'b0; req = '0; is_read = '0; resp_done = 1'b0;
      cfg_wr = 1'b1; cfg_app = a; cfg_limit = l; cfg_weight = w;
      e.nm = nm; e.g = '0; e.ci = 1'b0; e.idle = 1'b0; e.ce = 1'b0; e.err = 1'b0;
      q.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if (grant !== e.g) begin
               n_err++;
               $display("FAIL %s grant got=%b exp=%b", e.nm, grant, e.g);
            end
            if (e.ci) begin
               n_chk++;
               if (all_idle !== e.idle) begin
                  n_err++;
                  $display("FAIL %s all_idle got=%b exp=%b", e.nm, all_idle, e.idle);
               end
            end
            if (e.ce) begin
               n_chk++;
               if (err_underflow !== e.err) begin
                  n_err++;
                  $display("FAIL %s err_underflow got=%b exp=%b", e.nm, err_underflow, e.err);
               end
            end
         end
      end
   end

   initial begin
      cyc(1, 4'hF, 4'h0, 0, 0, 4'h0, 1, 1, 1, 0, "rst_state");
      cyc(0, 4'hF, 4'h0, 0, 0, 4'h1, 1, 1, 0, 0, "rr_a0");
      cyc(0, 4'hF, 4'h0, 0, 0, 4'h2, 0, 0, 0, 0, "rr_a1");
      cyc(0, 4'hF, 4'h0, 0, 0, 4'h4, 0, 0, 0, 0, "rr_a2");
      cyc(0, 4'hF, 4'h0, 0, 0, 4'h8, 0, 0, 0, 0, "rr_a3");
      cyc(0, 4'hF, 4'h0, 0, 0, 4'h1, 1, 1, 0, 0, "rr_wrap");

      cyc(1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, "rst_w");
      cfg(3'd1, 4'd8, 4'd3, "cfg_w1");
      cyc(0, 4'h3, 4'h0, 0, 0, 4'h1, 0, 0, 0, 0, "wgt_0a");
      cyc(0, 4'h3, 4'h0, 0, 0, 4'h2, 0, 0, 0, 0, "wgt_1a");
      cyc(0, 4'h3, 4'h0, 0, 0, 4'h2, 0, 0, 0, 0, "wgt_1b");
      cyc(0, 4'h3, 4'h0, 0, 0, 4'h2, 0, 0, 0, 0, "wgt_1c");
      cyc(0, 4'h3, 4'h0, 0, 0, 4'h1, 0, 0, 0, 0, "wgt_0b");
      cyc(0, 4'h3, 4'h0, 0, 0, 4'h2, 0, 0, 0, 0, "wgt_1d");
      cyc(0, 4'h3, 4'h0, 0, 0, 4'h2, 0, 0, 0, 0, "wgt_1e");
      cyc(0, 4'h3, 4'h0, 0, 0, 4'h2, 0, 0, 0, 0, "wgt_1f");
      cyc(0, 4'h3, 4'h0, 0, 0, 4'h1, 0, 0, 0, 0, "wgt_0c");

      cyc(1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, "rst_l");
      cfg(3'd2, 4'd2, 4'd1, "cfg_l2");
      cyc(0, 4'h4, 4'h4, 0, 0, 4'h4, 1, 1, 0, 0, "lim_g1");
      cyc(0, 4'h4, 4'h4, 0, 0, 4'h4, 1, 0, 0, 0, "lim_g2");
      cyc(0, 4'h4, 4'h4, 0, 0, 4'h0, 1, 0, 0, 0, "lim_blk");
      cyc(0, 4'h4, 4'h4, 1, 2, 4'h0, 1, 0, 0, 0, "lim_resp");
      cyc(0, 4'h4, 4'h4, 0, 0, 4'h4, 1, 0, 0, 0, "lim_g3");
      cyc(0, 4'h4, 4'h4, 0, 0, 4'h0, 1, 0, 0, 0, "lim_blk2");

      cyc(0, 4'h0, 4'h0, 1, 6, 4'h0, 1, 0, 1, 0, "bad_resp");
      cfg(3'd6, 4'd0, 4'd1, "bad_cfg");
      cyc(0, 4'h0, 4'h0, 1, 2, 4'h0, 1, 0, 1, 0, "drain1");
      cyc(0, 4'h0, 4'h0, 1, 2, 4'h0, 1, 0, 1, 0, "drain2");
      cyc(0, 4'h4, 4'h4, 0, 0, 4'h4, 1, 1, 1, 0, "lim_kept");
      cyc(0, 4'h0, 4'h0, 1, 2, 4'h0, 1, 0, 1, 0, "drain3");

      cyc(0, 4'h0, 4'h0, 1, 3, 4'h0, 1, 1, 1, 0, "uf_resp");
      cyc(0, 4'h0, 4'h0, 0, 0, 4'h0, 1, 1, 1, 1, "uf_set");
      cyc(0, 4'h0, 4'h0, 0, 0, 4'h0, 1, 1, 1, 1, "uf_hold");

      cyc(1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, "rst_s");
      cyc(0, 4'h1, 4'h1, 0, 0, 4'h1, 1, 1, 1, 0, "rd0");
      cyc(0, 4'h1, 4'h1, 1, 0, 4'h1, 1, 0, 0, 0, "rd_resp0");
      cyc(0, 4'h0, 4'h0, 0, 0, 4'h0, 1, 0, 1, 0, "same_cnt");
      cyc(0, 4'h0, 4'h0, 1, 0, 4'h0, 1, 0, 0, 0, "resp0");
      cyc(0, 4'h0, 4'h0, 0, 0, 4'h0, 1, 1, 1, 0, "drained");

      cfg(3'd0, 4'd0, 4'd1, "cfg_l0");
      cyc(0, 4'h1, 4'h1, 0, 0, 4'h0, 1, 1, 0, 0, "rd_blk");
      cyc(0, 4'h1, 4'h0, 0, 0, 4'h1, 1, 1, 0, 0, "wr_ok");
      cyc(0, 4'h0, 4'h0, 0, 0, 4'h0, 1, 1, 0, 0, "wr_nocnt");

      cyc(1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, "rst_m");
      cyc(0, 4'hB, 4'hB, 0, 0, 4'h1, 1, 1, 0, 0, "mid_g0");
      cyc(0, 4'hB, 4'hB, 0, 0, 4'h2, 1, 0, 0, 0, "mid_g1");
      cyc(0, 4'hB, 4'hB, 0, 0, 4'h8, 0, 0, 0, 0, "mid_g3");
      cyc(0, 4'hB, 4'hB, 0, 0, 4'h1, 0, 0, 0, 0, "mid_g0b");
      cyc(0, 4'h9, 4'h9, 0, 0, 4'h8, 0, 0, 0, 0, "mid_g3b");
      cyc(0, 4'h1, 4'h1, 0, 0, 4'h1, 1, 0, 0, 0, "mid_g0c");
      cyc(1, 4'hF, 4'h0, 0, 0, 4'h0, 1, 0, 0, 0, "rst_mid");
      cyc(0, 4'hE, 4'h0, 0, 0, 4'h2, 1, 1, 1, 0, "post_rst");
      cyc(0, 4'h0, 4'h0, 0, 0, 4'h0, 1, 1, 1, 0, "end");

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      if (q.size() > 0) begin
         n_chk++;
         n_err++;
         $display("FAIL drain pending=%0d exp=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
